matrix_scan_ctrl: RTL

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

---
 rtl/matrix_scan_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl
// Scans a Rows x Cols analog mux matrix in row-major order. For every pixel it
// waits SettleCycles for the mux to settle, fires a one-cycle ADC start pulse,
// waits for the ADC done pulse, then reports the sample and moves on.
//
// Build option: define SCAN_CONTINUOUS_EN to scan frames back-to-back until a
// stop request is seen. Otherwise each start_i produces exactly one frame and
// stop_i is unused.
module matrix_scan_ctrl #(
    parameter int Width        = 5,
    parameter int Rows         = 2,
    parameter int Cols         = 2,
    parameter int SettleCycles = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             adc_done_i,
    output logic [Width-1:0] row_o,
    output logic [Width-1:0] col_o,
    output logic             adc_start_o,
    output logic             sample_valid_o,
    output logic             frame_done_o,
    output logic             busy_o
);

    localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [CntW-1:0]  SettleLast = CntW'(SettleCycles - 1);
    localparam logic [Width-1:0] RowLast    = Width'(Rows - 1);
    localparam logic [Width-1:0] ColLast    = Width'(Cols - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CONVERT,
        WAIT,
        ADVANCE
    } state_t;

    state_t          state;
    logic [CntW-1:0] settle_cnt;
    logic            last_pixel;

    assign last_pixel = (row_o == RowLast) && (col_o == ColLast);

`ifdef SCAN_CONTINUOUS_EN
    logic stop_latch;
    logic stop_req;

    // A stop seen in the final ADVANCE cycle itself still ends the run.
    assign stop_req = stop_latch | stop_i;

    // Remember a stop request until the frame in progress has completed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stop_latch <= 1'b0;
        end else if (state == ADVANCE && last_pixel) begin
            stop_latch <= 1'b0;
        end else if (state != IDLE && stop_i) begin
            stop_latch <= 1'b1;
        end
    end
`else
    logic unused_stop;
    assign unused_stop = stop_i;
`endif

    // Scan sequencer: state, pixel address, settle timer and registered pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            row_o          <= '0;
            col_o          <= '0;
            settle_cnt     <= '0;
            adc_start_o    <= 1'b0;
            sample_valid_o <= 1'b0;
            frame_done_o   <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            adc_start_o    <= 1'b0;
            sample_valid_o <= 1'b0;
            frame_done_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= SETTLE;
                        busy_o     <= 1'b1;
                        row_o      <= '0;
                        col_o      <= '0;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SettleLast) begin
                        state       <= CONVERT;
                        adc_start_o <= 1'b1;
                        settle_cnt  <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + CntW'(1);
                    end
                end
                CONVERT: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // The sample and frame pulses cover the ADVANCE cycle,
                    // while row_o/col_o still name the converted pixel.
                    if (adc_done_i) begin
                        state          <= ADVANCE;
                        sample_valid_o <= 1'b1;
                        frame_done_o   <= last_pixel;
                    end
                end
                ADVANCE: begin
                    settle_cnt <= '0;
                    if (last_pixel) begin
                        row_o <= '0;
                        col_o <= '0;
`ifdef SCAN_CONTINUOUS_EN
                        if (stop_req) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state <= SETTLE;
                        end
`else
                        state  <= IDLE;
                        busy_o <= 1'b0;
`endif
                    end else begin
                        state <= SETTLE;
                        if (col_o == ColLast) begin
                            col_o <= '0;
                            row_o <= row_o + Width'(1);
                        end else begin
                            col_o <= col_o + Width'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
